// File: rtl/div64x32_pkg.sv
// Shared types and width-derived constants for the div64x32 restoring divider.
package div_pkg;

  localparam int OPWIDTH_DEF = 32;
  localparam int MAX_W       = 64;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;

  // Constants are built MAX_W wide; callers keep the low w bits.
  function automatic logic [MAX_W-1:0] all_ones(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return all_ones(w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div64x32_if.sv
// Operand/result handshake bundle for div64x32; master drives operands, slave is the divider.
interface div64x32_if
  import div_pkg::*;
#(
  parameter int OPWIDTH = OPWIDTH_DEF
);
  logic                   i_valid;
  logic                   o_ready;
  logic [2*OPWIDTH-1:0]   i_dvd;
  logic [OPWIDTH-1:0]     i_dvs;
  logic                   i_dvd_ns;
  logic                   i_dvs_ns;
  logic                   o_valid;
  logic                   i_res_rdy;
  logic [OPWIDTH-1:0]     o_quot;
  logic [OPWIDTH-1:0]     o_rem;
  logic                   o_dbz;
  logic                   o_ovf;
  logic                   o_chk_err;

  modport master (
    output i_valid, i_dvd, i_dvs, i_dvd_ns, i_dvs_ns, i_res_rdy,
    input  o_ready, o_valid, o_quot, o_rem, o_dbz, o_ovf, o_chk_err
  );

  modport slave (
    input  i_valid, i_dvd, i_dvs, i_dvd_ns, i_dvs_ns, i_res_rdy,
    output o_ready, o_valid, o_quot, o_rem, o_dbz, o_ovf, o_chk_err
  );
endinterface

// File: rtl/div64x32_sign_mag.sv
// Conditional two's-complement negate: magnitude extraction and sign application.
module div_sign_mag
  import div_pkg::*;
#(
  parameter int W = OPWIDTH_DEF
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (W'(0) - val) : val;
endmodule

// File: rtl/div64x32.sv
// Iterative restoring divider, 2N-bit dividend by N-bit divisor, per-operand signedness.
// Optional result self-check enabled by defining DIV64X32_SELFCHECK_EN.
module div64x32
  import div_pkg::*;
#(
  parameter int OPWIDTH = OPWIDTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  div64x32_if.slave   bus
);
  localparam int N  = OPWIDTH;
  localparam int CW = $clog2(N);
  localparam logic [MAX_W-1:0] ONES_W = all_ones(N);
  localparam logic [MAX_W-1:0] SPOS_W = sat_pos(N);
  localparam logic [MAX_W-1:0] SNEG_W = sat_neg(N);
  localparam logic [N-1:0] ALL_ONES = ONES_W[N-1:0];
  localparam logic [N-1:0] SAT_POS  = SPOS_W[N-1:0];
  localparam logic [N-1:0] SAT_NEG  = SNEG_W[N-1:0];

  div_state_t     state_reg;
  logic [2*N-1:0] dvd_reg;
  logic [N-1:0]   dvs_reg, dvs_mag_reg, part_reg, qs_reg, quot_reg, rem_reg;
  logic           dvd_ns_reg, dvs_ns_reg, sgn_reg, q_neg_reg, r_neg_reg;
  logic [CW-1:0]  cnt_reg;
  logic           ready_reg, valid_reg, dbz_reg, ovf_reg, chk_reg;

  logic           neg_dvd, neg_dvs, sgn_now, q_neg_now;
  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag, q_signed, r_signed;
  logic [N:0]     shifted, diff;
  logic           ge, q_ovf, chk_bad;

  assign neg_dvd   = dvd_ns_reg & dvd_reg[2*N-1];
  assign neg_dvs   = dvs_ns_reg & dvs_reg[N-1];
  assign sgn_now   = dvd_ns_reg | dvs_ns_reg;
  assign q_neg_now = neg_dvd ^ neg_dvs;

  div_sign_mag #(.W(2*N)) u_mag_dvd (.val(dvd_reg),  .neg(neg_dvd),   .res(dvd_mag));
  div_sign_mag #(.W(N))   u_mag_dvs (.val(dvs_reg),  .neg(neg_dvs),   .res(dvs_mag));
  div_sign_mag #(.W(N))   u_fix_q   (.val(qs_reg),   .neg(q_neg_reg), .res(q_signed));
  div_sign_mag #(.W(N))   u_fix_r   (.val(part_reg), .neg(r_neg_reg), .res(r_signed));

  // One restoring step: the shift can carry into bit N before the compare.
  assign shifted = {part_reg, qs_reg[N-1]};
  assign diff    = shifted - {1'b0, dvs_mag_reg};
  assign ge      = shifted >= {1'b0, dvs_mag_reg};

  // A negative signed quotient may reach 2^(N-1); a positive one may not.
  assign q_ovf = sgn_reg & (q_neg_reg ? (qs_reg > SAT_NEG) : (qs_reg >= SAT_NEG));

`ifdef DIV64X32_SELFCHECK_EN
  logic [2*N-1:0] chk_q, chk_d, chk_r, chk_sum;
  always_comb begin
    chk_q   = q_neg_reg ? ((2*N)'(0) - {{N{1'b0}}, qs_reg}) : {{N{1'b0}}, qs_reg};
    chk_r   = r_neg_reg ? ((2*N)'(0) - {{N{1'b0}}, part_reg}) : {{N{1'b0}}, part_reg};
    chk_d   = dvs_ns_reg ? {{N{dvs_reg[N-1]}}, dvs_reg} : {{N{1'b0}}, dvs_reg};
    chk_sum = chk_q * chk_d + chk_r;
    chk_bad = chk_sum != dvd_reg;
  end
`else
  assign chk_bad = 1'b0;
`endif

  function automatic logic [N-1:0] sat_value(input logic sgn, input logic qn);
    return sgn ? (qn ? SAT_NEG : SAT_POS) : ALL_ONES;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b1;
      valid_reg   <= 1'b0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      dbz_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
      chk_reg     <= 1'b0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      dvd_ns_reg  <= 1'b0;
      dvs_ns_reg  <= 1'b0;
      sgn_reg     <= 1'b0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      dvs_mag_reg <= '0;
      part_reg    <= '0;
      qs_reg      <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.i_valid) begin
          dvd_reg    <= bus.i_dvd;
          dvs_reg    <= bus.i_dvs;
          dvd_ns_reg <= bus.i_dvd_ns;
          dvs_ns_reg <= bus.i_dvs_ns;
          ready_reg  <= 1'b0;
          state_reg  <= PREP;
        end
        PREP: begin
          sgn_reg     <= sgn_now;
          q_neg_reg   <= q_neg_now;
          r_neg_reg   <= neg_dvd;
          dvs_mag_reg <= dvs_mag;
          part_reg    <= dvd_mag[2*N-1:N];
          qs_reg      <= dvd_mag[N-1:0];
          cnt_reg     <= CW'(N - 1);
          chk_reg     <= 1'b0;
          if (dvs_reg == '0) begin
            quot_reg  <= ALL_ONES;
            rem_reg   <= dvd_reg[N-1:0];
            dbz_reg   <= 1'b1;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
            // Quotient needs more than N magnitude bits: saturate immediately.
            quot_reg  <= sat_value(sgn_now, q_neg_now);
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
            ovf_reg   <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= CALC;
          end
        end
        CALC: begin
          part_reg <= ge ? diff[N-1:0] : shifted[N-1:0];
          qs_reg   <= {qs_reg[N-2:0], ge};
          cnt_reg  <= cnt_reg - CW'(1);
          if (cnt_reg == '0) state_reg <= FIX;
        end
        FIX: begin
          dbz_reg   <= 1'b0;
          valid_reg <= 1'b1;
          state_reg <= DONE;
          if (q_ovf) begin
            quot_reg <= sat_value(sgn_reg, q_neg_reg);
            rem_reg  <= '0;
            ovf_reg  <= 1'b1;
            chk_reg  <= 1'b0;
          end else begin
            quot_reg <= q_signed;
            rem_reg  <= r_signed;
            ovf_reg  <= 1'b0;
            chk_reg  <= chk_bad;
          end
        end
        DONE: if (bus.i_res_rdy) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_quot    = quot_reg;
  assign bus.o_rem     = rem_reg;
  assign bus.o_dbz     = dbz_reg;
  assign bus.o_ovf     = ovf_reg;
  assign bus.o_chk_err = chk_reg;

endmodule

// File: tb/tb_div64x32.sv
// Randomized bench for div64x32 against a wide-integer truncating-division model.
module tb_div64x32;
  import div_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div64x32_if #(.OPWIDTH(N)) bus ();

  div64x32 #(.OPWIDTH(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Exact quotient/remainder from 66-bit signed arithmetic, then range rules.
  function automatic exp_t model(input logic [63:0] dvd, input logic [31:0] dvs,
                                 input logic dns, input logic sns);
    logic signed [65:0] a, b, q, r, aq;
    exp_t e;
    a = dns ? {{2{dvd[63]}}, dvd} : {2'b00, dvd};
    b = sns ? {{34{dvs[31]}}, dvs} : {34'd0, dvs};
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.q   = 32'hFFFF_FFFF;
      e.r   = dvd[31:0];
      e.lat = 1;
      return e;
    end
    q  = a / b;
    r  = a % b;
    aq = (q < 0) ? -q : q;
    e.lat = (aq >= 66'sd4294967296) ? 1 : N + 2;
    e.q   = q[31:0];
    e.r   = r[31:0];
    if (!dns && !sns) begin
      if (q > 66'sd4294967295) begin
        e.ovf = 1'b1; e.q = 32'hFFFF_FFFF; e.r = '0;
      end
    end else if (q > 66'sd2147483647) begin
      e.ovf = 1'b1; e.q = 32'h7FFF_FFFF; e.r = '0;
    end else if (q < -66'sd2147483648) begin
      e.ovf = 1'b1; e.q = 32'h8000_0000; e.r = '0;
    end
    return e;
  endfunction

  // Result checker: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.o_valid, 1'b0);
      end else begin
        check("quot",    bus.o_quot,    exp_q[0].q);
        check("rem",     bus.o_rem,     exp_q[0].r);
        check("dbz",     bus.o_dbz,     exp_q[0].dbz);
        check("ovf",     bus.o_ovf,     exp_q[0].ovf);
        check("chk_err", bus.o_chk_err, 1'b0);
        check("ready_busy", bus.o_ready, 1'b0);
      end
    end
  end

  task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs,
                        input logic dns, input logic sns, input int hold);
    exp_t e;
    int   t;
    int   lat;
    e = model(dvd, dvs, dns, sns);
    t = 0;
    while (!bus.o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) check("ready_timeout", bus.o_ready, 1'b1);
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_dvd    = dvd;
    bus.i_dvs    = dvs;
    bus.i_dvd_ns = dns;
    bus.i_dvs_ns = sns;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.o_valid && lat < 100);
    check("latency", lat, e.lat);
    $display("op dvd=%h dvs=%h ns=%b%b -> quot=%h rem=%h dbz=%b ovf=%b lat=%0d",
             dvd, dvs, dns, sns, bus.o_quot, bus.o_rem, bus.o_dbz, bus.o_ovf, lat);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.i_res_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.i_res_rdy = 1'b0;
    void'(exp_q.pop_front());
    check("valid_after_take", bus.o_valid, 1'b0);
    check("ready_after_take", bus.o_ready, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, bus.o_ready,   1'b1);
    check({tag, "_valid"}, bus.o_valid,   1'b0);
    check({tag, "_quot"},  bus.o_quot,    32'd0);
    check({tag, "_rem"},   bus.o_rem,     32'd0);
    check({tag, "_dbz"},   bus.o_dbz,     1'b0);
    check({tag, "_ovf"},   bus.o_ovf,     1'b0);
    check({tag, "_chk"},   bus.o_chk_err, 1'b0);
  endtask

  initial begin
    exp_t        p;
    logic [63:0] dvd;
    logic [31:0] dvs, lo;
    logic        dns, sns;
    int          mode;

    bus.i_valid   = 1'b0;
    bus.i_dvd     = '0;
    bus.i_dvs     = '0;
    bus.i_dvd_ns  = 1'b0;
    bus.i_dvs_ns  = 1'b0;
    bus.i_res_rdy = 1'b0;

    // Pin the model against hand-computed results.
    p = model(64'd4096, 32'd64, 1'b0, 1'b0);
    check("pin_u_q", p.q, 32'd64);  check("pin_u_lat", p.lat, 34);
    p = model(64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1'b1, 1'b1);
    check("pin_s_q", p.q, 32'hFFFF_FFFD);  check("pin_s_r", p.r, 32'hFFFF_FFFF);
    p = model(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0, 1'b0);
    check("pin_dbz_r", p.r, 32'h9ABC_DEF0);  check("pin_dbz_lat", p.lat, 1);
    p = model(64'h1_0000_0000, 32'd1, 1'b0, 1'b0);
    check("pin_uovf_q", p.q, 32'hFFFF_FFFF);  check("pin_uovf_f", p.ovf, 1'b1);
    p = model(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("pin_sovf_q", p.q, 32'h7FFF_FFFF);  check("pin_sovf_lat", p.lat, 34);

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors; the first one holds the result for 10 cycles.
    run_op(64'd4096, 32'd64, 1'b0, 1'b0, 10);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0, 1'b0, 2);
    run_op(64'h1_0000_0000, 32'd1, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    run_op(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, 1'b1, 0);
    run_op(64'h0000_0000_8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);

    // Reset in the middle of CALC drops the operation.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_dvd   = 64'd1000;
    bus.i_dvs   = 32'd7;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd1000, 32'd7, 1'b0, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 4);
      dvs  = $urandom;
      lo   = $urandom;
      dns  = $urandom_range(0, 1);
      sns  = $urandom_range(0, 1);
      case (mode)
        0: begin
          dns = 1'b0; sns = 1'b0;
          dvd = {(dvs == 0) ? 32'd0 : ($urandom % dvs), lo};
        end
        1: begin
          dns = 1'b1; sns = 1'b1;
          dvd = {{32{lo[31]}}, lo};
        end
        2: dvd = {$urandom, lo};
        3: begin
          dvd = {{16{lo[15]}}, lo[15:0], $urandom};
        end
        default: begin
          dvd = {$urandom, lo};
          dvs = {{30{dvs[31]}}, dvs[1:0]};
        end
      endcase
      run_op(dvd, dvs, dns, sns, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
